// File: rtl/uart_sample_bridge.sv
// rtl/uart_sample_bridge.sv - byte/sample adapter between UART byte FIFOs and the biquad datapath
//
// RX side pops bytes from the RX FIFO and assembles little-endian SW-bit samples,
// presenting each on a valid/ready port. A partially assembled sample is dropped
// after TO_CYC idle cycles. TX side accepts SW-bit results on a valid/ready port
// and pushes them to the TX FIFO LSB byte first, stalling on tx_full.
//
// Ports:
//   clk, reset               system clock, synchronous active-high reset
//   rx_empty, r_data         RX FIFO status and first-word-fall-through head byte
//   rd_uart                  RX FIFO pop strobe
//   tx_full                  TX FIFO full
//   wr_uart, w_data          TX FIFO push strobe and byte
//   s_out, s_out_valid       assembled sample to the filter
//   s_out_ready              filter accepts s_out
//   s_in, s_in_valid         filter result
//   s_in_ready               bridge accepts s_in
module uart_sample_bridge #(
    parameter int SW     = 16,
    parameter int TO_CYC = 4096,
    parameter int TO_W   = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx_empty,
    input  logic [7:0]    r_data,
    output logic          rd_uart,
    input  logic          tx_full,
    output logic          wr_uart,
    output logic [7:0]    w_data,
    output logic [SW-1:0] s_out,
    output logic          s_out_valid,
    input  logic          s_out_ready,
    input  logic [SW-1:0] s_in,
    input  logic          s_in_valid,
    output logic          s_in_ready
);

    localparam int NB = SW / 8;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BW-1:0]   LAST_IDX = BW'(NB - 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TO_CYC - 1);

    // ---------------- RX assembly ----------------
    logic [BW-1:0]   bidx;
    logic [TO_W-1:0] to_cnt;
    logic [SW-1:0]   asm_q;
    logic [SW-1:0]   asm_next;
    logic            stall;

    // The final byte of a sample must stay in the FIFO while the previous
    // sample is still waiting for the filter, otherwise it would be overwritten.
    assign stall = (bidx == LAST_IDX) && s_out_valid && !s_out_ready;

    always_comb begin
        rd_uart = !reset && !rx_empty && !stall;
    end

    // Assembly register with the current head byte merged in; on the last
    // byte this is the complete sample.
    always_comb begin
        asm_next               = asm_q;
        asm_next[8*bidx +: 8]  = r_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bidx        <= '0;
            to_cnt      <= '0;
            asm_q       <= '0;
            s_out       <= '0;
            s_out_valid <= 1'b0;
        end else begin
            if (s_out_valid && s_out_ready)
                s_out_valid <= 1'b0;
            if (rd_uart) begin
                asm_q  <= asm_next;
                to_cnt <= '0;
                if (bidx == LAST_IDX) begin
                    bidx        <= '0;
                    s_out       <= asm_next;
                    s_out_valid <= 1'b1;   // overrides a same-cycle handshake clear
                end else begin
                    bidx <= bidx + 1'b1;
                end
            end else if (bidx != '0) begin
                if (to_cnt == TO_LAST) begin
                    bidx   <= '0;
                    to_cnt <= '0;
                    asm_q  <= '0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

    // ---------------- TX serialiser ----------------
    typedef enum logic {T_IDLE, T_SEND} tx_state_t;

    tx_state_t     state;
    tx_state_t     state_next;
    logic [SW-1:0] shreg;
    logic [BW-1:0] bcnt;
    logic          push;

    always_comb begin
        state_next = state;
        s_in_ready = 1'b0;
        push       = 1'b0;
        case (state)
            T_IDLE: begin
                s_in_ready = 1'b1;
                if (s_in_valid)
                    state_next = T_SEND;
            end
            T_SEND: begin
                push = !tx_full && !reset;
                if (push && bcnt == '0)
                    state_next = T_IDLE;
            end
            default: state_next = T_IDLE;
        endcase
        wr_uart = push;
        w_data  = shreg[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= T_IDLE;
            shreg <= '0;
            bcnt  <= '0;
        end else begin
            state <= state_next;
            if (state == T_IDLE && s_in_valid) begin
                shreg <= s_in;
                bcnt  <= LAST_IDX;
            end else if (push) begin
                shreg <= shreg >> 8;
                bcnt  <= bcnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_sample_bridge.sv
// tb/tb_uart_sample_bridge.sv - self-checking bench for uart_sample_bridge
module tb_uart_sample_bridge;

    localparam int SW     = 16;
    localparam int NB     = SW / 8;
    localparam int TO_CYC = 4096;
    localparam int TO_W   = 12;

    logic          clk;
    logic          reset;
    logic          rx_empty;
    logic [7:0]    r_data;
    logic          rd_uart;
    logic          tx_full;
    logic          wr_uart;
    logic [7:0]    w_data;
    logic [SW-1:0] s_out;
    logic          s_out_valid;
    logic          s_out_ready;
    logic [SW-1:0] s_in;
    logic          s_in_valid;
    logic          s_in_ready;

    uart_sample_bridge #(.SW(SW), .TO_CYC(TO_CYC), .TO_W(TO_W)) dut (
        .clk(clk), .reset(reset),
        .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
        .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data),
        .s_out(s_out), .s_out_valid(s_out_valid), .s_out_ready(s_out_ready),
        .s_in(s_in), .s_in_valid(s_in_valid), .s_in_ready(s_in_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // environment FIFO and behavioural model state
    logic [7:0]    rxq[$];
    logic [7:0]    part[$];
    logic [7:0]    txq[$];
    logic [SW-1:0] held;
    logic          held_v;
    int            idle;

    // observation logs
    int            n_rd, n_wr, n_valid, n_nr;
    logic [7:0]    tx_log[$];
    logic [SW-1:0] out_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_stats();
        n_rd = 0; n_wr = 0; n_valid = 0; n_nr = 0;
        tx_log.delete();
        out_log.delete();
    endtask

    task automatic drive_rx();
        rx_empty = (rxq.size() == 0);
        r_data   = (rxq.size() != 0) ? rxq[0] : 8'h00;
    endtask

    task automatic push_rx(input logic [7:0] b);
        rxq.push_back(b);
        drive_rx();
    endtask

    // One clock: compare at negedge against the model, advance model at posedge.
    task automatic tick();
        logic          exp_rd, exp_wr, exp_rdy, hs, dut_pop;
        logic [7:0]    head;
        logic [SW-1:0] v;
        @(negedge clk);
        head    = (rxq.size() != 0) ? rxq[0] : 8'h00;
        exp_rd  = !reset && rxq.size() != 0 &&
                  !(part.size() == NB - 1 && held_v && !s_out_ready);
        exp_wr  = !reset && txq.size() != 0 && !tx_full;
        exp_rdy = (txq.size() == 0);
        check("rd_uart", {31'd0, rd_uart}, {31'd0, exp_rd});
        check("wr_uart", {31'd0, wr_uart}, {31'd0, exp_wr});
        if (!reset) begin
            check("s_in_ready", {31'd0, s_in_ready}, {31'd0, exp_rdy});
            check("s_out_valid", {31'd0, s_out_valid}, {31'd0, held_v});
            if (held_v) check("s_out", 32'(s_out), 32'(held));
            if (exp_wr) check("w_data", 32'(w_data), 32'(txq[0]));
            if (rd_uart) n_rd++;
            if (wr_uart) begin n_wr++; tx_log.push_back(w_data); end
            if (s_out_valid) n_valid++;
            if (!s_in_ready) n_nr++;
            if (s_out_valid && s_out_ready) out_log.push_back(s_out);
        end
        dut_pop = rd_uart;
        @(posedge clk);
        if (dut_pop && rxq.size() != 0) void'(rxq.pop_front());
        if (reset) begin
            part.delete(); txq.delete();
            held = '0; held_v = 1'b0; idle = 0;
        end else begin
            hs = held_v && s_out_ready;
            if (hs) held_v = 1'b0;
            if (exp_rd) begin
                part.push_back(head);
                idle = 0;
                if (part.size() == NB) begin
                    v = '0;
                    for (int i = 0; i < NB; i++) v = v | (SW'(part[i]) << (8 * i));
                    held = v; held_v = 1'b1;
                    part.delete();
                end
            end else if (part.size() != 0) begin
                idle++;
                if (idle == TO_CYC) begin part.delete(); idle = 0; end
            end else begin
                idle = 0;
            end
            if (exp_wr) void'(txq.pop_front());
            if (exp_rdy && s_in_valid)
                for (int i = 0; i < NB; i++) txq.push_back(s_in[8*i +: 8]);
        end
        #1;
        drive_rx();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset = 1'b1; rx_empty = 1'b1; r_data = 8'h00; tx_full = 1'b0;
        s_out_ready = 1'b0; s_in = '0; s_in_valid = 1'b0;
        held = '0; held_v = 1'b0; idle = 0;
        clear_stats();
        @(posedge clk); #1;
        ticks(2);
        reset = 1'b0;
        check("reset_s_out", 32'(s_out), 32'h0);
        check("reset_s_out_valid", {31'd0, s_out_valid}, 32'd0);
        check("reset_s_in_ready", {31'd0, s_in_ready}, 32'd1);
        check("reset_wr_uart", {31'd0, wr_uart}, 32'd0);

        // 1: two bytes assemble to 0x1234, valid one cycle
        clear_stats();
        s_out_ready = 1'b1;
        push_rx(8'h34); push_rx(8'h12);
        ticks(6);
        check("t1_rd_count", n_rd, 2);
        check("t1_valid_count", n_valid, 1);
        check("t1_nsamples", out_log.size(), 1);
        if (out_log.size() == 1) check("t1_sample", 32'(out_log[0]), 32'h1234);

        // 2: held sample stalls only the final byte of the next one
        clear_stats();
        s_out_ready = 1'b0;
        push_rx(8'h01); push_rx(8'h00); push_rx(8'h02); push_rx(8'h00);
        ticks(8);
        check("t2_held_valid", {31'd0, s_out_valid}, 32'd1);
        check("t2_held_data", 32'(s_out), 32'h0001);
        check("t2_rd_stalled", {31'd0, rd_uart}, 32'd0);
        check("t2_fifo_left", rxq.size(), 1);
        s_out_ready = 1'b1;
        ticks(6);
        check("t2_nsamples", out_log.size(), 2);
        if (out_log.size() == 2) begin
            check("t2_sample0", 32'(out_log[0]), 32'h0001);
            check("t2_sample1", 32'(out_log[1]), 32'h0002);
        end

        // 3: timeout discards 0xAA after exactly TO_CYC idle cycles
        clear_stats();
        push_rx(8'hAA);
        tick();
        ticks(TO_CYC);
        push_rx(8'h78); push_rx(8'h56);
        ticks(6);
        check("t3_nsamples", out_log.size(), 1);
        if (out_log.size() == 1) check("t3_sample", 32'(out_log[0]), 32'h5678);

        // 3b: one idle cycle short of the timeout keeps the partial byte
        clear_stats();
        push_rx(8'h11);
        tick();
        ticks(TO_CYC - 1);
        push_rx(8'h22);
        ticks(4);
        check("t3b_nsamples", out_log.size(), 1);
        if (out_log.size() == 1) check("t3b_sample", 32'(out_log[0]), 32'h2211);

        // 4: TX 0xBEEF serialised LSB first
        clear_stats();
        s_in = 16'hBEEF; s_in_valid = 1'b1;
        tick();
        s_in_valid = 1'b0;
        ticks(5);
        check("t4_wr_count", n_wr, 2);
        check("t4_notready", n_nr, 2);
        if (tx_log.size() == 2) begin
            check("t4_byte0", 32'(tx_log[0]), 32'hEF);
            check("t4_byte1", 32'(tx_log[1]), 32'hBE);
        end

        // 5: tx_full stall of 10 cycles after the first byte
        clear_stats();
        s_in = 16'hBEEF; s_in_valid = 1'b1;
        tick();
        s_in_valid = 1'b0;
        tick();
        tx_full = 1'b1;
        ticks(10);
        tx_full = 1'b0;
        ticks(3);
        check("t5_wr_count", n_wr, 2);
        check("t5_notready", n_nr, 12);
        if (tx_log.size() == 2) begin
            check("t5_byte0", 32'(tx_log[0]), 32'hEF);
            check("t5_byte1", 32'(tx_log[1]), 32'hBE);
        end

        // 6: reset mid-sample and mid-send
        clear_stats();
        push_rx(8'h99);
        ticks(2);
        s_in = 16'h1357; s_in_valid = 1'b1;
        tick();
        s_in_valid = 1'b0;
        tick();
        push_rx(8'hCD);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_s_out", 32'(s_out), 32'h0);
        check("t6_s_out_valid", {31'd0, s_out_valid}, 32'd0);
        check("t6_wr_uart", {31'd0, wr_uart}, 32'd0);
        check("t6_s_in_ready", {31'd0, s_in_ready}, 32'd1);
        push_rx(8'hAB);
        ticks(6);
        check("t6_wr_count", n_wr, 1);
        if (tx_log.size() == 1) check("t6_byte0", 32'(tx_log[0]), 32'h57);
        check("t6_nsamples", out_log.size(), 1);
        if (out_log.size() == 1) check("t6_sample", 32'(out_log[0]), 32'hABCD);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
